// File: rtl/alu_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_pkg
// Description : Opcode constants, flag-vector type and flag-update helper
//               shared by the ALU and its writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_wb_pkg;

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_NOT = 3'b100;

    // Architectural flag vector, packed as {z, c, v}
    typedef struct packed {
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Arithmetic ops own all three flags, logic ops only own z,
    // anything above NOT leaves the flags alone.
    function automatic flags_t flags_next(input flags_t cur,
                                          input logic [2:0] sel,
                                          input flags_t ent);
        flags_t nxt;
        nxt = cur;
        case (sel)
            c_OP_ADD, c_OP_SUB:           nxt = ent;
            c_OP_AND, c_OP_OR, c_OP_NOT:  nxt.z = ent.z;
            default:                      nxt = cur;
        endcase
        return nxt;
    endfunction

    // Opcodes beyond NOT write back a zero result
    function automatic logic wb_zero(input logic [2:0] sel);
        return (sel > c_OP_NOT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_skid_fifo
// Description : Two-entry skid FIFO of generic width. The head entry is a
//               register that drives the output directly, so the output
//               holds its last value when the FIFO drains empty.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_skid_fifo
    import alu_wb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push_valid,
    output logic              o_push_ready,
    input  logic [DATA_W-1:0] i_push_data,
    output logic              o_pop_valid,
    input  logic              i_pop_ready,
    output logic [DATA_W-1:0] o_pop_data
);

    logic [1:0]        r_count;
    logic              r_live;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic              w_push;
    logic              w_pop;

    // Ready depends only on registered state; r_live keeps it low until
    // the first edge after reset release.
    assign o_push_ready = r_live && (r_count != 2'd2);
    assign o_pop_valid  = (r_count != 2'd0);
    assign o_pop_data   = r_head;
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = o_pop_valid && i_pop_ready;

    // Occupancy and storage update; tail shifts into head on every pop from full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live  <= 1'b0;
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_live <= 1'b1;
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_push_data;
                    else                 r_tail <= i_push_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) r_head <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                // Push implies count < 2 and pop implies count > 0, so one entry
                // is held: the newcomer replaces it as head.
                2'b11: r_head <= i_push_data;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_wb.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb
// Description : ALU writeback stage: buffers results in a 2-entry skid FIFO,
//               updates architectural flags and counts retired writebacks.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wb
    import alu_wb_pkg::*;
#(
    parameter int RD_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_res,
    input  logic             in_z,
    input  logic             in_c,
    input  logic             in_v,
    input  logic [2:0]       in_sel,
    input  logic [RD_W-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic [RD_W-1:0]  out_rd,
    output logic [2:0]       flags_q,
    output logic [CNT_W-1:0] retired_cnt
);

    // Entry layout, LSB first: rd, sel, flags, res
    localparam int SEL_LO = RD_W;
    localparam int FLG_LO = RD_W + 3;
    localparam int RES_LO = RD_W + 6;
    localparam int DATA_W = RD_W + 38;

    logic [DATA_W-1:0] w_push_data;
    logic [DATA_W-1:0] w_head;
    logic [31:0]       w_res_eff;
    logic              w_retire;
    flags_t            w_head_flags;
    flags_t            r_flags;
    logic [CNT_W-1:0]  r_cnt;

    // Zeroing is done on entry so the head register already holds the
    // writeback value and stays stable while stalled.
    assign w_res_eff   = wb_zero(in_sel) ? 32'd0 : in_res;
    assign w_push_data = {w_res_eff, in_z, in_c, in_v, in_sel, in_rd};

    wb_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push_valid (in_valid),
        .o_push_ready (in_ready),
        .i_push_data  (w_push_data),
        .o_pop_valid  (out_valid),
        .i_pop_ready  (out_ready),
        .o_pop_data   (w_head)
    );

    assign w_retire     = out_valid && out_ready;
    assign w_head_flags = w_head[FLG_LO +: 3];
    assign out_res      = w_head[RES_LO +: 32];
    assign out_rd       = w_head[RD_W-1:0];
    assign flags_q      = r_flags;
    assign retired_cnt  = r_cnt;

    // Flags and retire counter advance on the retire handshake edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= '0;
            r_cnt   <= '0;
        end else if (w_retire) begin
            r_flags <= flags_next(r_flags, w_head[SEL_LO +: 3], w_head_flags);
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_wb
// Description : Self-checking bench for alu_wb: directed vector table,
//               randomized traffic against a queue-based reference model,
//               counter wrap and mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_wb;

    localparam int RD_W  = 3;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_res;
    logic             in_z, in_c, in_v;
    logic [2:0]       in_sel;
    logic [RD_W-1:0]  in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_res;
    logic [RD_W-1:0]  out_rd;
    logic [2:0]       flags_q;
    logic [CNT_W-1:0] retired_cnt;

    alu_wb #(.RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_res      (in_res),
        .in_z        (in_z),
        .in_c        (in_c),
        .in_v        (in_v),
        .in_sel      (in_sel),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res     (out_res),
        .out_rd      (out_rd),
        .flags_q     (flags_q),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state: pending results in acceptance order
    typedef struct {
        logic [31:0] res;
        logic        z, c, v;
        logic [2:0]  sel;
        logic [2:0]  rd;
    } ent_t;

    ent_t        q[$];
    logic [2:0]  m_flags;
    int          m_cnt;
    logic [31:0] m_last_res;
    logic [2:0]  m_last_rd;
    bit          m_live;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        iv;
        logic [31:0] res;
        logic        z, c, v;
        logic [2:0]  sel;
        logic [2:0]  rd;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_res;
        logic [2:0]  e_rd;
        logic [2:0]  e_fl;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wb_val(input ent_t e);
        return (e.sel >= 3'd5) ? 32'd0 : e.res;
    endfunction

    task automatic model_clear();
        q.delete();
        m_flags    = 3'b000;
        m_cnt      = 0;
        m_last_res = 32'd0;
        m_last_rd  = 3'd0;
        m_live     = 1'b0;
    endtask

    task automatic check_model();
        logic [31:0] er;
        logic [2:0]  ed;
        er = (q.size() > 0) ? wb_val(q[0]) : m_last_res;
        ed = (q.size() > 0) ? q[0].rd : m_last_rd;
        check("m_in_ready",  {31'd0, in_ready},  {31'd0, (m_live && q.size() < 2)});
        check("m_out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
        check("m_out_res",   out_res, er);
        check("m_out_rd",    {29'd0, out_rd}, {29'd0, ed});
        check("m_flags",     {29'd0, flags_q}, {29'd0, m_flags});
        check("m_cnt",       {28'd0, retired_cnt}, m_cnt);
    endtask

    // One clock: compare against the model, then advance the model at the edge
    task automatic step();
        bit   acc, ret;
        ent_t e, n;
        check_model();
        acc = in_valid && m_live && (q.size() < 2);
        ret = out_ready && (q.size() > 0);
        n.res = in_res; n.z = in_z; n.c = in_c; n.v = in_v; n.sel = in_sel; n.rd = in_rd;
        @(posedge clk);
        if (ret) begin
            e = q.pop_front();
            case (e.sel)
                3'd0, 3'd1:       m_flags = {e.z, e.c, e.v};
                3'd2, 3'd3, 3'd4: m_flags[2] = e.z;
                default:          m_flags = m_flags;
            endcase
            m_cnt      = (m_cnt + 1) % 16;
            m_last_res = wb_val(e);
            m_last_rd  = e.rd;
        end
        if (acc) q.push_back(n);
        m_live = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_res = 0; in_z = 0; in_c = 0; in_v = 0; in_sel = 0; in_rd = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_res",   out_res, 32'd0);
        check("rst_out_rd",    {29'd0, out_rd}, 32'd0);
        check("rst_flags",     {29'd0, flags_q}, 32'd0);
        check("rst_cnt",       {28'd0, retired_cnt}, 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        out_ready = 0;
        model_clear();

        // Directed vectors: inputs for the cycle, outputs seen before its edge
        //          iv  res     z  c  v  sel   rd    rdy  ir ov  e_res   e_rd  e_fl    cnt
        tbl[0]  = '{1, 32'h5,  0, 1, 0, 3'd0, 3'd3, 1,   1, 0, 32'h0,  3'd0, 3'b000, 4'd0};
        tbl[1]  = '{0, 32'h0,  0, 0, 0, 3'd0, 3'd0, 1,   1, 1, 32'h5,  3'd3, 3'b000, 4'd0};
        tbl[2]  = '{0, 32'h0,  0, 0, 0, 3'd0, 3'd0, 0,   1, 0, 32'h5,  3'd3, 3'b010, 4'd1};
        tbl[3]  = '{1, 32'h11, 0, 0, 1, 3'd1, 3'd1, 0,   1, 0, 32'h5,  3'd3, 3'b010, 4'd1};
        tbl[4]  = '{1, 32'h22, 1, 0, 0, 3'd3, 3'd2, 0,   1, 1, 32'h11, 3'd1, 3'b010, 4'd1};
        tbl[5]  = '{1, 32'h33, 1, 1, 1, 3'd0, 3'd4, 0,   0, 1, 32'h11, 3'd1, 3'b010, 4'd1};
        tbl[6]  = '{1, 32'h33, 1, 1, 1, 3'd0, 3'd4, 0,   0, 1, 32'h11, 3'd1, 3'b010, 4'd1};
        tbl[7]  = '{1, 32'h33, 1, 1, 1, 3'd0, 3'd4, 1,   0, 1, 32'h11, 3'd1, 3'b010, 4'd1};
        tbl[8]  = '{1, 32'h33, 1, 1, 1, 3'd0, 3'd4, 1,   1, 1, 32'h22, 3'd2, 3'b001, 4'd2};
        tbl[9]  = '{0, 32'h0,  0, 0, 0, 3'd0, 3'd0, 1,   1, 1, 32'h33, 3'd4, 3'b101, 4'd3};
        tbl[10] = '{0, 32'h0,  0, 0, 0, 3'd0, 3'd0, 0,   1, 0, 32'h33, 3'd4, 3'b111, 4'd4};
        tbl[11] = '{1, 32'h44, 0, 1, 1, 3'd0, 3'd5, 1,   1, 0, 32'h33, 3'd4, 3'b111, 4'd4};
        tbl[12] = '{1, 32'h55, 1, 0, 0, 3'd2, 3'd6, 1,   1, 1, 32'h44, 3'd5, 3'b111, 4'd4};
        tbl[13] = '{1, 32'h66, 0, 0, 0, 3'd6, 3'd7, 1,   1, 1, 32'h55, 3'd6, 3'b011, 4'd5};
        tbl[14] = '{0, 32'h0,  0, 0, 0, 3'd0, 3'd0, 1,   1, 1, 32'h0,  3'd7, 3'b111, 4'd6};
        tbl[15] = '{0, 32'h0,  0, 0, 0, 3'd0, 3'd0, 1,   1, 0, 32'h0,  3'd7, 3'b111, 4'd7};
        tbl[16] = '{0, 32'h0,  0, 0, 0, 3'd0, 3'd0, 0,   1, 0, 32'h0,  3'd7, 3'b111, 4'd7};

        @(negedge clk);
        do_reset();
        step();

        for (int i = 0; i < 17; i++) begin
            in_valid  = tbl[i].iv;
            in_res    = tbl[i].res;
            in_z      = tbl[i].z;
            in_c      = tbl[i].c;
            in_v      = tbl[i].v;
            in_sel    = tbl[i].sel;
            in_rd     = tbl[i].rd;
            out_ready = tbl[i].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, tbl[i].e_ir});
            check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
            check($sformatf("vec%0d_out_res", i),   out_res, tbl[i].e_res);
            check($sformatf("vec%0d_out_rd", i),    {29'd0, out_rd},  {29'd0, tbl[i].e_rd});
            check($sformatf("vec%0d_flags", i),     {29'd0, flags_q}, {29'd0, tbl[i].e_fl});
            check($sformatf("vec%0d_cnt", i),       {28'd0, retired_cnt}, {28'd0, tbl[i].e_cnt});
            step();
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_res    = $urandom;
            in_z      = $urandom_range(0, 1);
            in_c      = $urandom_range(0, 1);
            in_v      = $urandom_range(0, 1);
            in_sel    = 3'($urandom_range(0, 7));
            in_rd     = 3'($urandom_range(0, 7));
            step();
        end

        // Counter wrap: 17 retires on a 4-bit counter
        idle_inputs();
        out_ready = 0;
        do_reset();
        step();
        out_ready = 1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1;
            in_res   = 32'(i + 1);
            in_sel   = 3'(i % 8);
            in_rd    = 3'(i % 8);
            in_z     = i[0];
            in_c     = i[1];
            in_v     = i[2];
            step();
        end
        in_valid = 0;
        step();
        step();
        check("cnt_wrap", {28'd0, retired_cnt}, 32'd1);

        // Mid-operation reset with two entries buffered
        out_ready = 0;
        in_valid  = 1;
        in_sel    = 3'd0;
        in_z = 1; in_c = 1; in_v = 1;
        in_res = 32'hAAAA; in_rd = 3'd1;
        step();
        in_res = 32'hBBBB; in_rd = 3'd2;
        step();
        check("mid_full_out_valid", {31'd0, out_valid}, 32'd1);
        check("mid_full_in_ready",  {31'd0, in_ready},  32'd0);
        #2;
        do_reset();
        idle_inputs();
        out_ready = 1;
        for (int i = 0; i < 4; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
